// File: rtl/boreal_pkg.sv
`default_nettype none
// ============================================================================
// Module : boreal_pkg
// Brief  : Shared types and constants for the Boreal telemetry sequencer:
//          FSM state encoding, frame sync word, status register map and the
//          header word builder.
// Rev    : 1.0  initial release
// ============================================================================
package boreal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_H_RD   = 3'd1,
    ST_H_CAP  = 3'd2,
    ST_S_HDR  = 3'd3,
    ST_S_RD   = 3'd4,
    ST_S_CAP  = 3'd5,
    ST_S_SEND = 3'd6
  } state_t;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hB0EA;
  localparam logic [15:0] DEAD_WORD         = 16'hDEAD;

  // Status register map
  localparam logic [2:0] ADDR_MU     = 3'd0;
  localparam logic [2:0] ADDR_SIGMA  = 3'd1;
  localparam logic [2:0] ADDR_RHO    = 3'd2;
  localparam logic [2:0] ADDR_PHI    = 3'd3;
  localparam logic [2:0] ADDR_THETA1 = 3'd4;
  localparam logic [2:0] ADDR_THETA2 = 3'd5;

  // Frame word 1: sequence number in the top byte, register count in the low bits
  function automatic logic [15:0] header_word(input logic [7:0] seq, input logic [2:0] nregs);
    return {seq, 5'd0, nregs};
  endfunction

endpackage
`default_nettype wire

// File: rtl/boreal_period_timer.sv
`default_nettype none
// ============================================================================
// Module : boreal_period_timer
// Brief  : Free-running sweep period counter. Raises a single pending sweep
//          request on each wrap and flags a sticky overrun when a wrap lands
//          while a sweep is already pending or in progress.
// Rev    : 1.0  initial release
// ============================================================================
module boreal_period_timer #(
  parameter int PERIOD_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic sweep_en,
  input  logic sweep_active,
  input  logic sweep_take,
  input  logic overrun_clr,
  output logic sweep_pend,
  output logic overrun
);

  localparam int             CW         = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST_COUNT = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] count;
  logic          wrap;
  logic          trigger;
  logic          collide;

  assign wrap    = (count == LAST_COUNT);
  assign trigger = wrap && sweep_en;
  // A trigger never queues behind another one: it becomes an overrun instead.
  assign collide = sweep_pend || sweep_active;

  // Period counter 0..PERIOD_CYCLES-1, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (wrap) count <= '0;
    else           count <= count + CW'(1);
  end

  // Pending sweep flag, consumed by the sequencer when it starts a frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       sweep_pend <= 1'b0;
    else if (trigger && !collide)  sweep_pend <= 1'b1;
    else if (sweep_take)           sweep_pend <= 1'b0;
  end

  // Sticky overrun; a clear beats a same-cycle set
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     overrun <= 1'b0;
    else if (overrun_clr)        overrun <= 1'b0;
    else if (trigger && collide) overrun <= 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/boreal_telemetry_sequencer.sv
`default_nettype none
// ============================================================================
// Module : boreal_telemetry_sequencer
// Brief  : Arbitrates the Boreal status register file between host single
//          reads and a periodic telemetry sweep, and streams each sweep as a
//          framed, XOR-checksummed packet on a valid/ready word stream.
// Rev    : 1.0  initial release
// ============================================================================
module boreal_telemetry_sequencer
  import boreal_pkg::*;
#(
  parameter int          PERIOD_CYCLES = 50000,
  parameter int          NUM_REGS      = 6,
  parameter logic [15:0] SYNC_WORD     = SYNC_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sweep_en,
  input  logic        host_req,
  input  logic [2:0]  host_addr,
  output logic        host_ack,
  output logic [15:0] host_data,
  output logic [2:0]  reg_addr,
  output logic        reg_rd_en,
  input  logic [15:0] reg_rd_data,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        overrun,
  input  logic        overrun_clr,
  output logic [7:0]  frame_seq
);

  // Word numbering inside a frame: 0 sync, 1 header, 2.. registers, then checksum
  localparam logic [3:0] REG_FIRST   = 4'd2;
  localparam logic [3:0] WORD_CHK    = 4'(NUM_REGS + 2);
  localparam logic [3:0] WORD_END    = 4'(NUM_REGS + 3);
  localparam logic [2:0] NREGS_FIELD = 3'(NUM_REGS);

  state_t        state, state_n;
  state_t        ret_st, ret_n;
  state_t        resume;
  logic [3:0]    wcnt, wcnt_n, w_next;
  logic [15:0]   chk, chk_n;
  logic          tx_valid_n, tx_last_n;
  logic [15:0]   tx_data_n;
  logic [7:0]    seq_n;
  logic          host_pend, host_pend_n;
  logic [2:0]    haddr, haddr_n;
  logic [15:0]   host_data_q, host_data_q_n;
  logic [2:0]    addr_hold;
  logic [2:0]    reg_idx;
  logic [15:0]   hdr_word;
  logic          sweep_pend;
  logic          sweep_take;
  logic          sweep_active;
  logic          accept;

  assign accept   = tx_valid && tx_ready;
  assign w_next   = wcnt + 4'd1;
  assign reg_idx  = 3'(wcnt - REG_FIRST);
  assign hdr_word = header_word(frame_seq, NREGS_FIELD);

  // A host read that interrupts a frame still counts as sweep activity.
  assign sweep_active = (state == ST_S_HDR) || (state == ST_S_RD) ||
                        (state == ST_S_CAP) || (state == ST_S_SEND) ||
                        (((state == ST_H_RD) || (state == ST_H_CAP)) && (ret_st != ST_IDLE));

  // Register file strobes; the address holds its last value between reads
  assign reg_rd_en = (state == ST_H_RD) || (state == ST_S_RD);
  assign reg_addr  = (state == ST_H_RD) ? haddr :
                     (state == ST_S_RD) ? reg_idx : addr_hold;

  // Host result is presented in the ack cycle straight from the register file, then held
  assign host_ack  = (state == ST_H_CAP);
  assign host_data = (state == ST_H_CAP) ? reg_rd_data : host_data_q;

  boreal_period_timer #(
    .PERIOD_CYCLES (PERIOD_CYCLES)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .sweep_en     (sweep_en),
    .sweep_active (sweep_active),
    .sweep_take   (sweep_take),
    .overrun_clr  (overrun_clr),
    .sweep_pend   (sweep_pend),
    .overrun      (overrun)
  );

  // Where the frame continues after the word currently being accepted
  always_comb begin
    resume = ST_IDLE;
    if (w_next == WORD_END)
      resume = ST_IDLE;
    else if ((w_next >= REG_FIRST) && (w_next < WORD_CHK))
      resume = ST_S_RD;
    else
      resume = ST_S_HDR;
  end

  // Next-state and datapath updates for the sequencer
  always_comb begin
    state_n       = state;
    ret_n         = ret_st;
    wcnt_n        = wcnt;
    chk_n         = chk;
    tx_valid_n    = tx_valid;
    tx_data_n     = tx_data;
    tx_last_n     = tx_last;
    seq_n         = frame_seq;
    host_data_q_n = host_data_q;
    host_pend_n   = host_pend;
    haddr_n       = haddr;
    sweep_take    = 1'b0;

    // A request arriving while one is outstanding is dropped
    if (host_req && !host_pend) begin
      host_pend_n = 1'b1;
      haddr_n     = host_addr;
    end

    case (state)
      ST_IDLE: begin
        if (host_pend) begin
          state_n = ST_H_RD;
          ret_n   = ST_IDLE;
        end else if (sweep_pend) begin
          state_n    = ST_S_HDR;
          sweep_take = 1'b1;
          wcnt_n     = 4'd0;
          chk_n      = 16'd0;
        end
      end

      ST_H_RD: state_n = ST_H_CAP;

      ST_H_CAP: begin
        host_data_q_n = reg_rd_data;
        host_pend_n   = 1'b0;
        state_n       = ret_st;
      end

      // Non-register words: sync, header, or checksum after a host interruption
      ST_S_HDR: begin
        tx_valid_n = 1'b1;
        tx_data_n  = (wcnt == 4'd0) ? SYNC_WORD :
                     (wcnt == 4'd1) ? hdr_word  : chk;
        tx_last_n  = (wcnt == WORD_CHK);
        state_n    = ST_S_SEND;
      end

      ST_S_RD: state_n = ST_S_CAP;

      ST_S_CAP: begin
        tx_valid_n = 1'b1;
        tx_data_n  = reg_rd_data;
        tx_last_n  = 1'b0;
        state_n    = ST_S_SEND;
      end

      ST_S_SEND: begin
        if (accept) begin
          chk_n      = chk ^ tx_data;
          wcnt_n     = w_next;
          tx_valid_n = 1'b0;
          tx_last_n  = 1'b0;
          if (tx_last)
            seq_n = frame_seq + 8'd1;
          if (host_pend) begin
            state_n = ST_H_RD;
            ret_n   = resume;
          end else if (resume == ST_S_HDR) begin
            // Header and checksum follow back-to-back without an extra cycle
            tx_valid_n = 1'b1;
            tx_data_n  = (w_next == 4'd1) ? hdr_word : (chk ^ tx_data);
            tx_last_n  = (w_next == WORD_CHK);
          end else begin
            state_n = resume;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ret_st      <= ST_IDLE;
      wcnt        <= 4'd0;
      chk         <= 16'd0;
      tx_valid    <= 1'b0;
      tx_data     <= 16'd0;
      tx_last     <= 1'b0;
      frame_seq   <= 8'd0;
      host_data_q <= 16'd0;
      host_pend   <= 1'b0;
      haddr       <= 3'd0;
      addr_hold   <= 3'd0;
    end else begin
      state       <= state_n;
      ret_st      <= ret_n;
      wcnt        <= wcnt_n;
      chk         <= chk_n;
      tx_valid    <= tx_valid_n;
      tx_data     <= tx_data_n;
      tx_last     <= tx_last_n;
      frame_seq   <= seq_n;
      host_data_q <= host_data_q_n;
      host_pend   <= host_pend_n;
      haddr       <= haddr_n;
      addr_hold   <= reg_addr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_boreal_telemetry_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_boreal_telemetry_sequencer
// Brief  : Directed self-checking bench for boreal_telemetry_sequencer with a
//          behavioural status register file and a stream word collector.
// Rev    : 1.0  initial release
// ============================================================================
module tb_boreal_telemetry_sequencer;
  import boreal_pkg::*;

  localparam int PERIOD      = 64;
  localparam int NREGS       = 6;
  localparam int FRAME_WORDS = NREGS + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sweep_en = 1'b0;
  logic        host_req = 1'b0;
  logic [2:0]  host_addr = 3'd0;
  logic        host_ack;
  logic [15:0] host_data;
  logic [2:0]  reg_addr;
  logic        reg_rd_en;
  logic [15:0] reg_rd_data = 16'd0;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_last;
  logic        tx_ready = 1'b1;
  logic        overrun;
  logic        overrun_clr = 1'b0;
  logic [7:0]  frame_seq;

  int errors = 0;
  int checks = 0;

  logic [15:0] regs [6] = '{16'h1234, 16'h0001, 16'h0003, 16'h0010, 16'h0AAA, 16'h0555};

  logic [15:0] q_data [$];
  logic        q_last [$];
  logic [7:0]  q_seq  [$];
  int          frames_seen = 0;
  int          ack_count   = 0;

  always #5 clk = ~clk;

  boreal_telemetry_sequencer #(
    .PERIOD_CYCLES (PERIOD),
    .NUM_REGS      (NREGS),
    .SYNC_WORD     (16'hB0EA)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sweep_en    (sweep_en),
    .host_req    (host_req),
    .host_addr   (host_addr),
    .host_ack    (host_ack),
    .host_data   (host_data),
    .reg_addr    (reg_addr),
    .reg_rd_en   (reg_rd_en),
    .reg_rd_data (reg_rd_data),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .frame_seq   (frame_seq)
  );

  // Status register file: registered read, unmapped addresses return DEAD
  always @(posedge clk) begin
    if (reg_rd_en)
      reg_rd_data <= (reg_addr < 3'd6) ? regs[reg_addr] : DEAD_WORD;
  end

  // Stream collector and ack counter, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      frames_seen = 0;
    end else begin
      if (tx_valid && tx_ready) begin
        q_data.push_back(tx_data);
        q_last.push_back(tx_last);
        if (tx_last) begin
          q_seq.push_back(8'(frames_seen));
          frames_seen++;
        end
      end
      if (host_ack) ack_count++;
    end
  end

  function automatic logic [15:0] exp_word(input int i, input logic [7:0] seq);
    logic [15:0] acc;
    if (i == 0) return 16'hB0EA;
    if (i == 1) return {seq, 8'h06};
    if (i < FRAME_WORDS - 1) return regs[i-2];
    acc = 16'hB0EA ^ {seq, 8'h06};
    for (int k = 0; k < NREGS; k++) acc = acc ^ regs[k];
    return acc;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    q_data.delete();
    q_last.delete();
    q_seq.delete();
  endtask

  task automatic drain();
    sweep_en = 1'b0;
    tx_ready = 1'b1;
    cycles(120);
    clear_queues();
  endtask

  task automatic wait_words(input int n, output bit ok);
    int t;
    t = 0;
    while (q_data.size() < n && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    ok = (q_data.size() >= n);
  endtask

  task automatic get_frame(output logic [FRAME_WORDS-1:0][15:0] w,
                           output logic [FRAME_WORDS-1:0] l,
                           output logic [7:0] s, output bit ok);
    int t;
    t = 0; w = '0; l = '0; s = '0;
    while (q_seq.size() == 0 && t < 400) begin
      @(negedge clk); #1;
      t++;
    end
    ok = (q_seq.size() != 0) && (q_data.size() >= FRAME_WORDS);
    if (ok) begin
      s = q_seq.pop_front();
      for (int i = 0; i < FRAME_WORDS; i++) begin
        w[i] = q_data.pop_front();
        l[i] = q_last.pop_front();
      end
    end
  endtask

  task automatic test_reset();
    logic [47:0] v;
    #12;
    v = {tx_valid, tx_last, host_ack, reg_rd_en, overrun, reg_addr, frame_seq, tx_data, host_data};
    checks++;
    if (v !== 48'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", v);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_sweep();
    logic [FRAME_WORDS-1:0][15:0] w;
    logic [FRAME_WORDS-1:0] l;
    logic [7:0] s;
    bit ok;
    tx_ready = 1'b1;
    sweep_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      get_frame(w, l, s, ok);
      if (f == 1) sweep_en = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL sweep_frame%0d: no frame, got timeout want frame", f);
      end else begin
        for (int i = 0; i < FRAME_WORDS; i++) begin
          checks++;
          if (w[i] !== exp_word(i, s) || l[i] !== (i == FRAME_WORDS - 1)) begin
            errors++;
            $display("FAIL sweep_f%0d_word%0d: got %h last=%b want %h last=%b",
                     f, i, w[i], l[i], exp_word(i, s), (i == FRAME_WORDS - 1));
          end
        end
        checks++;
        if (w[1] !== ((f == 0) ? 16'h0006 : 16'h0106)) begin
          errors++;
          $display("FAIL sweep_header%0d: got %h want %h", f, w[1], (f == 0) ? 16'h0006 : 16'h0106);
        end
        if (f == 0) begin
          checks++;
          if (w[8] !== 16'hAD35) begin
            errors++;
            $display("FAIL sweep_checksum0: got %h want AD35", w[8]);
          end
        end
      end
    end
    cycles(3);
    checks++;
    if (frame_seq !== 8'd2) begin
      errors++;
      $display("FAIL sweep_frame_seq: got %0d want 2", frame_seq);
    end
  endtask

  task automatic test_host();
    logic [2:0]  addrs [2];
    logic [15:0] expd  [2];
    int lat;
    logic [15:0] dat;
    addrs[0] = ADDR_RHO; expd[0] = 16'h0003;
    addrs[1] = 3'd7;     expd[1] = DEAD_WORD;
    drain();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      host_addr = addrs[k];
      host_req  = 1'b1;
      @(posedge clk); #1;
      host_req  = 1'b0;
      host_addr = 3'd0;
      lat = 0; dat = 16'd0;
      for (int c = 1; c <= 6 && lat == 0; c++) begin
        @(negedge clk);
        if (host_ack) begin
          lat = c;
          dat = host_data;
        end
      end
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL host_latency_a%0d: got %0d want 3", addrs[k], lat);
      end
      checks++;
      if (dat !== expd[k]) begin
        errors++;
        $display("FAIL host_data_a%0d: got %h want %h", addrs[k], dat, expd[k]);
      end
      @(negedge clk);
      checks++;
      if (host_data !== expd[k] || host_ack !== 1'b0) begin
        errors++;
        $display("FAIL host_hold_a%0d: got %h ack=%b want %h ack=0", addrs[k], host_data, host_ack, expd[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [FRAME_WORDS-1:0][15:0] w;
    logic [FRAME_WORDS-1:0] l;
    logic [7:0] s;
    logic [15:0] held;
    bit ok;
    int bad, t;
    drain();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp_overrun_pre: got %b want 0", overrun);
    end
    sweep_en = 1'b1;
    wait_words(2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_start: got timeout want 2 words");
    end
    @(posedge clk); #1 tx_ready = 1'b0;
    t = 0;
    while (!tx_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    held = tx_data;
    checks++;
    if (held !== 16'h1234 || tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_word3: got %h valid=%b want 1234 valid=1", held, tx_valid);
    end
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== held) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable cycles want 0", bad);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_overrun_set: got %b want 1", overrun);
    end
    @(posedge clk); #1;
    sweep_en    = 1'b0;
    overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp_overrun_clr: got %b want 0", overrun);
    end
    tx_ready = 1'b1;
    cycles(250);
    checks++;
    if (q_seq.size() < 1 || q_seq.size() > 2) begin
      errors++;
      $display("FAIL bp_frame_count: got %0d want 1..2", q_seq.size());
    end
    get_frame(w, l, s, ok);
    for (int i = 0; i < FRAME_WORDS; i++) begin
      checks++;
      if (!ok || w[i] !== exp_word(i, s) || l[i] !== (i == FRAME_WORDS - 1)) begin
        errors++;
        $display("FAIL bp_word%0d: got %h last=%b want %h", i, w[i], l[i], exp_word(i, s));
      end
    end
  endtask

  task automatic test_host_during_stall();
    logic [FRAME_WORDS-1:0][15:0] w;
    logic [FRAME_WORDS-1:0] l;
    logic [7:0] s;
    bit ok;
    int a0, lat, t;
    logic [15:0] dat;
    drain();
    sweep_en = 1'b1;
    wait_words(2, ok);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    sweep_en = 1'b0;
    t = 0;
    while (!tx_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    a0 = ack_count;
    cycles(3);
    host_addr = ADDR_THETA1; host_req = 1'b1;
    @(posedge clk); #1 host_req = 1'b0;
    cycles(2);
    host_addr = ADDR_THETA2; host_req = 1'b1;
    @(posedge clk); #1 host_req = 1'b0;
    cycles(20);
    checks++;
    if (ack_count != a0 || tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL hs_midword: got acks=%0d valid=%b want acks=%0d valid=1", ack_count - a0, tx_valid, 0);
    end
    tx_ready = 1'b1;
    @(posedge clk);
    lat = 0; dat = 16'd0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      if (host_ack) begin
        lat = c;
        dat = host_data;
      end
    end
    checks++;
    if (lat < 1 || lat > 3) begin
      errors++;
      $display("FAIL hs_latency: got %0d want 1..3", lat);
    end
    checks++;
    if (dat !== 16'h0AAA) begin
      errors++;
      $display("FAIL hs_data: got %h want 0aaa", dat);
    end
    get_frame(w, l, s, ok);
    for (int i = 0; i < FRAME_WORDS; i++) begin
      checks++;
      if (!ok || w[i] !== exp_word(i, s) || l[i] !== (i == FRAME_WORDS - 1)) begin
        errors++;
        $display("FAIL hs_word%0d: got %h last=%b want %h", i, w[i], l[i], exp_word(i, s));
      end
    end
    cycles(30);
    checks++;
    if (ack_count != a0 + 1) begin
      errors++;
      $display("FAIL hs_ack_count: got %0d want 1", ack_count - a0);
    end
  endtask

  task automatic test_sweep_en_drop();
    logic [FRAME_WORDS-1:0][15:0] w;
    logic [FRAME_WORDS-1:0] l;
    logic [7:0] s;
    bit ok;
    drain();
    sweep_en = 1'b1;
    wait_words(3, ok);
    sweep_en = 1'b0;
    get_frame(w, l, s, ok);
    for (int i = 0; i < FRAME_WORDS; i++) begin
      checks++;
      if (!ok || w[i] !== exp_word(i, s) || l[i] !== (i == FRAME_WORDS - 1)) begin
        errors++;
        $display("FAIL drop_word%0d: got %h last=%b want %h", i, w[i], l[i], exp_word(i, s));
      end
    end
    cycles(200);
    checks++;
    if (q_data.size() != 0) begin
      errors++;
      $display("FAIL drop_no_more: got %0d words want 0", q_data.size());
    end
  endtask

  task automatic test_midrun_reset();
    logic [FRAME_WORDS-1:0][15:0] w;
    logic [FRAME_WORDS-1:0] l;
    logic [7:0] s;
    logic [47:0] v;
    bit ok;
    drain();
    sweep_en = 1'b1;
    wait_words(4, ok);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    v = {tx_valid, tx_last, host_ack, reg_rd_en, overrun, reg_addr, frame_seq, tx_data, host_data};
    checks++;
    if (v !== 48'd0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got %h want 0", v);
    end
    cycles(2);
    rst = 1'b0;
    clear_queues();
    get_frame(w, l, s, ok);
    sweep_en = 1'b0;
    checks++;
    if (!ok || w[1] !== 16'h0006) begin
      errors++;
      $display("FAIL midrun_header: got %h want 0006", w[1]);
    end
    for (int i = 0; i < FRAME_WORDS; i++) begin
      checks++;
      if (!ok || w[i] !== exp_word(i, 8'd0) || l[i] !== (i == FRAME_WORDS - 1)) begin
        errors++;
        $display("FAIL midrun_word%0d: got %h last=%b want %h", i, w[i], l[i], exp_word(i, 8'd0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_host();
    test_backpressure();
    test_host_during_stall();
    test_sweep_en_drop();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
